// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game playfield logic.
package snake_pkg;

    typedef logic [3:0] coord_t;

    localparam int         GRID_DIM          = 16;
    localparam logic [7:0] LFSR_SEED_DEFAULT = 8'hA5;

    typedef enum logic {
        SPAWN,
        ACTIVE
    } apple_state_t;

    // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
    endfunction

endpackage

// File: rtl/apple_lfsr.sv
// Free-running 8-bit maximal-length LFSR used to pick apple positions.
module apple_lfsr
    import snake_pkg::*;
#(
    parameter logic [7:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] value
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= SEED;
        end else begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/apple_manager.sv
// Apple placement and eat detection for the 16x16 playfield.
// Optional macro APPLE_COUNT_EN adds the saturating apple_count output.
module apple_manager
    import snake_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED  = LFSR_SEED_DEFAULT
`ifdef APPLE_COUNT_EN
   ,parameter int         MAX_APPLES = 60
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       move_tick,
    input  coord_t     head_x,
    input  coord_t     head_y,
    output coord_t     apple_x,
    output coord_t     apple_y,
    output logic       apple_valid,
    output logic       apple_eaten
`ifdef APPLE_COUNT_EN
   ,output logic [5:0] apple_count
`endif
);

    apple_state_t state;
    logic [7:0]   lfsr;
    coord_t       cand_x;
    coord_t       cand_y;
    logic         head_on_cand;
    logic         head_on_apple;

    apple_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .value (lfsr)
    );

    assign cand_x        = lfsr[7:4];
    assign cand_y        = lfsr[3:0];
    assign head_on_cand  = (cand_x == head_x) && (cand_y == head_y);
    assign head_on_apple = (apple_x == head_x) && (apple_y == head_y);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SPAWN;
            apple_x     <= '0;
            apple_y     <= '0;
            apple_valid <= 1'b0;
            apple_eaten <= 1'b0;
        end else begin
            case (state)
                SPAWN: begin
                    apple_eaten <= 1'b0;
                    // Never drop an apple under the head; next LFSR value is tried instead
                    if (!head_on_cand) begin
                        apple_x     <= cand_x;
                        apple_y     <= cand_y;
                        apple_valid <= 1'b1;
                        state       <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (move_tick && head_on_apple) begin
                        apple_eaten <= 1'b1;
                        apple_valid <= 1'b0;
                        state       <= SPAWN;
                    end else begin
                        apple_eaten <= 1'b0;
                    end
                end
                default: begin
                    state       <= SPAWN;
                    apple_eaten <= 1'b0;
                    apple_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef APPLE_COUNT_EN
    localparam logic [5:0] COUNT_MAX = 6'(MAX_APPLES);

    // Counts on the same edge that raises apple_eaten
    always_ff @(posedge clk) begin
        if (reset) begin
            apple_count <= '0;
        end else if (state == ACTIVE && move_tick && head_on_apple
                     && apple_count != COUNT_MAX) begin
            apple_count <= apple_count + 6'd1;
        end
    end
`endif

endmodule

// File: tb/tb_apple_manager.sv
// Self-checking bench for apple_manager: directed vector table, random run
// against a sequence-indexed reference model, and (with APPLE_COUNT_EN) saturation.
module tb_apple_manager;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       move_tick = 1'b0;
    logic [3:0] head_x = 4'd0;
    logic [3:0] head_y = 4'd0;
    logic [3:0] apple_x;
    logic [3:0] apple_y;
    logic       apple_valid;
    logic       apple_eaten;
`ifdef APPLE_COUNT_EN
    logic [5:0] apple_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    apple_manager dut (
        .clk         (clk),
        .reset       (reset),
        .move_tick   (move_tick),
        .head_x      (head_x),
        .head_y      (head_y),
        .apple_x     (apple_x),
        .apple_y     (apple_y),
        .apple_valid (apple_valid),
        .apple_eaten (apple_eaten)
`ifdef APPLE_COUNT_EN
       ,.apple_count (apple_count)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       tick;
        logic [3:0] hx;
        logic [3:0] hy;
        logic       ev;
        logic       ee;
        logic [3:0] ex;
        logic [3:0] ey;
    } vec_t;

    vec_t vecs[14];

    // Positions the LFSR presents on successive edges after reset release
    logic [7:0] seq[255];

    // reference model state
    int         m_n;
    bit         m_spawning;
    logic [3:0] m_x, m_y;
    logic       m_valid, m_eaten;
    int         m_count;

    task automatic model_reset();
        m_n = 0; m_spawning = 1; m_x = 0; m_y = 0;
        m_valid = 0; m_eaten = 0; m_count = 0;
    endtask

    task automatic model_edge(input logic rst, input logic tick, input logic [3:0] hx, input logic [3:0] hy);
        logic [7:0] cand;
        if (rst) begin
            model_reset();
            return;
        end
        cand = seq[m_n % 255];
        m_n++;
        if (m_spawning) begin
            m_eaten = 0;
            if (cand != {hx, hy}) begin
                m_x = cand[7:4]; m_y = cand[3:0];
                m_valid = 1; m_spawning = 0;
            end
        end else if (tick && hx == m_x && hy == m_y) begin
            m_eaten = 1; m_valid = 0; m_spawning = 1;
            if (m_count < 60) m_count++;
        end else begin
            m_eaten = 0;
        end
    endtask

    initial begin
        logic [7:0] s;
        s = 8'hA5;
        for (int i = 0; i < 255; i++) begin
            seq[i] = s;
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end

        // rst tick hx hy | valid eaten x y  (state after the edge)
        vecs[0]  = '{1'b1, 1'b0, 4'd0,  4'd0,  1'b0, 1'b0, 4'd0,  4'd0};
        vecs[1]  = '{1'b0, 1'b0, 4'd0,  4'd0,  1'b1, 1'b0, 4'd10, 4'd5};
        vecs[2]  = '{1'b0, 1'b0, 4'd10, 4'd5,  1'b1, 1'b0, 4'd10, 4'd5};
        vecs[3]  = '{1'b0, 1'b0, 4'd10, 4'd5,  1'b1, 1'b0, 4'd10, 4'd5};
        vecs[4]  = '{1'b0, 1'b1, 4'd3,  4'd3,  1'b1, 1'b0, 4'd10, 4'd5};
        vecs[5]  = '{1'b0, 1'b1, 4'd10, 4'd5,  1'b0, 1'b1, 4'd10, 4'd5};
        vecs[6]  = '{1'b0, 1'b0, 4'd10, 4'd5,  1'b1, 1'b0, 4'd10, 4'd9};
        vecs[7]  = '{1'b1, 1'b1, 4'd10, 4'd9,  1'b0, 1'b0, 4'd0,  4'd0};
        vecs[8]  = '{1'b0, 1'b0, 4'd10, 4'd5,  1'b0, 1'b0, 4'd0,  4'd0};
        vecs[9]  = '{1'b0, 1'b0, 4'd10, 4'd5,  1'b1, 1'b0, 4'd4,  4'd10};
        vecs[10] = '{1'b0, 1'b1, 4'd4,  4'd10, 1'b0, 1'b1, 4'd4,  4'd10};
        vecs[11] = '{1'b0, 1'b0, 4'd4,  4'd10, 1'b1, 1'b0, 4'd2,  4'd10};
        vecs[12] = '{1'b0, 1'b1, 4'd2,  4'd10, 1'b0, 1'b1, 4'd2,  4'd10};
        vecs[13] = '{1'b1, 1'b0, 4'd2,  4'd10, 1'b0, 1'b0, 4'd0,  4'd0};

        for (int i = 0; i < 14; i++) begin
            reset = vecs[i].rst; move_tick = vecs[i].tick;
            head_x = vecs[i].hx; head_y = vecs[i].hy;
            @(posedge clk); #1;
            chk($sformatf("vec%0d valid", i), apple_valid, vecs[i].ev);
            chk($sformatf("vec%0d eaten", i), apple_eaten, vecs[i].ee);
            chk($sformatf("vec%0d apple_x", i), apple_x, vecs[i].ex);
            chk($sformatf("vec%0d apple_y", i), apple_y, vecs[i].ey);
`ifdef APPLE_COUNT_EN
            if (vecs[i].rst) chk($sformatf("vec%0d count", i), apple_count, 0);
`endif
        end

        // Random run; head is biased onto the apple or the next candidate
        reset = 1; move_tick = 0;
        @(posedge clk); #1;
        model_reset();
        reset = 0;
        for (int c = 0; c < 3000; c++) begin
            int r;
            logic [7:0] nc;
            r = $urandom_range(0, 9);
            reset = ($urandom_range(0, 199) == 0);
            move_tick = $urandom_range(0, 1);
            nc = seq[m_n % 255];
            if (m_spawning && r < 4) begin
                head_x = nc[7:4]; head_y = nc[3:0];
            end else if (!m_spawning && r < 6) begin
                head_x = m_x; head_y = m_y;
            end else begin
                head_x = 4'($urandom_range(0, 15));
                head_y = 4'($urandom_range(0, 15));
            end
            @(posedge clk);
            model_edge(reset, move_tick, head_x, head_y);
            #1;
            chk("rand valid", apple_valid, m_valid);
            chk("rand eaten", apple_eaten, m_eaten);
            chk("rand apple_x", apple_x, m_x);
            chk("rand apple_y", apple_y, m_y);
`ifdef APPLE_COUNT_EN
            chk("rand count", apple_count, m_count);
`endif
            reset = 0;
        end

`ifdef APPLE_COUNT_EN
        begin
            int pulses;
            int w;
            pulses = 0;
            reset = 1; move_tick = 0;
            @(posedge clk); #1;
            reset = 0;
            for (int e = 0; e < 62; e++) begin
                move_tick = 0;
                w = 0;
                while (!apple_valid && w < 40) begin
                    @(posedge clk); #1; w++;
                end
                if (!apple_valid) begin
                    chk("sat wait valid", apple_valid, 1);
                    break;
                end
                head_x = apple_x; head_y = apple_y; move_tick = 1;
                @(posedge clk); #1;
                move_tick = 0;
                if (apple_eaten) pulses++;
                chk("sat count", apple_count, (e + 1 > 60) ? 60 : e + 1);
                @(posedge clk); #1;
                chk("sat pulse width", apple_eaten, 0);
            end
            chk("sat pulses", pulses, 62);
            chk("sat final count", apple_count, 60);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
